// File: rtl/sensor_init_seq.sv
// sensor_init_seq: walks a register-write table in an external synchronous ROM.
// It issues each write to the shared I2C master, retries NACKed or timed-out
// writes, and inserts programmable delays for 8'hFF entries. It reports the
// outcome on init_done or on init_err/err_index.
//
// I2C handshake: i2c_req is a one-cycle request. i2c_reg_addr/i2c_wr_data are
// stable from i2c_req until the matching i2c_done pulse. i2c_nack only has
// meaning in the cycle i2c_done is high, and i2c_done is ignored outside
// WAIT_ACK.
module sensor_init_seq #(
    parameter int NUM_ENTRIES = 64,
    parameter int ROM_AW      = 6,
    parameter int DELAY_UNIT  = 50000,
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_start,
    output logic              init_done,
    output logic              init_err,
    output logic              busy,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              i2c_req,
    output logic [7:0]        i2c_reg_addr,
    output logic [7:0]        i2c_wr_data,
    input  logic              i2c_done,
    input  logic              i2c_nack,
    output logic [ROM_AW-1:0] err_index
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int DW = $clog2(255 * DELAY_UNIT + 1);
    // At least one bit, so that MAX_RETRY=0 still gives a legal counter.
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [ROM_AW-1:0] LAST_IDX  = ROM_AW'(NUM_ENTRIES - 1);
    localparam logic [TW-1:0]     TO_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0]     RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [DW-1:0]     DU        = DW'(DELAY_UNIT);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        LATCH    = 4'd2,
        DECODE   = 4'd3,
        ISSUE    = 4'd4,
        WAIT_ACK = 4'd5,
        DELAY    = 4'd6,
        NEXT     = 4'd7,
        DONE     = 4'd8,
        ERROR    = 4'd9
    } state_t;

    state_t            state, state_next;
    logic [ROM_AW-1:0] index, index_next;
    logic [15:0]       entry, entry_next;
    logic [RW-1:0]     retry, retry_next;
    logic [DW-1:0]     delay_cnt, delay_next;
    logic [TW-1:0]     to_cnt, to_next;
    logic [ROM_AW-1:0] err_q, err_next;

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            entry     <= '0;
            retry     <= '0;
            delay_cnt <= '0;
            to_cnt    <= '0;
            err_q     <= '0;
        end else begin
            state     <= state_next;
            index     <= index_next;
            entry     <= entry_next;
            retry     <= retry_next;
            delay_cnt <= delay_next;
            to_cnt    <= to_next;
            err_q     <= err_next;
        end
    end

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_next = state;
        index_next = index;
        entry_next = entry;
        retry_next = retry;
        delay_next = delay_cnt;
        to_next    = to_cnt;
        err_next   = err_q;
        case (state)
            IDLE, DONE, ERROR: begin
                if (init_start) begin
                    state_next = FETCH;
                    index_next = '0;
                    err_next   = '0;
                end
            end
            FETCH: state_next = LATCH;
            LATCH: begin
                entry_next = rom_data;
                state_next = DECODE;
            end
            DECODE: begin
                if (entry[15:8] == 8'hFF) begin
                    if (entry[7:0] == 8'h00) begin
                        state_next = NEXT;
                    end else begin
                        delay_next = DW'(entry[7:0]) * DU;
                        state_next = DELAY;
                    end
                end else begin
                    retry_next = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // The request cycle counts as the first elapsed cycle. The
                // timeout then fires ACK_TIMEOUT cycles after i2c_req.
                to_next    = TW'(1);
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (i2c_done && !i2c_nack) begin
                    state_next = NEXT;
                end else if (i2c_done || (to_cnt >= TO_LAST)) begin
                    if (retry < RETRY_LIM) begin
                        retry_next = retry + 1'b1;
                        state_next = ISSUE;
                    end else begin
                        err_next   = index;
                        state_next = ERROR;
                    end
                end else begin
                    to_next = to_cnt + 1'b1;
                end
            end
            DELAY: begin
                delay_next = delay_cnt - 1'b1;
                if (delay_cnt == DW'(1)) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (index == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    index_next = index + 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from registered state. i2c_req is additionally
    // gated by reset so that an abort drops the request in the same cycle.
    assign busy         = !((state == IDLE) || (state == DONE) || (state == ERROR));
    assign init_done    = (state == DONE);
    assign init_err     = (state == ERROR);
    assign rom_addr     = index;
    assign i2c_req      = (state == ISSUE) && !reset;
    assign i2c_reg_addr = entry[15:8];
    assign i2c_wr_data  = entry[7:0];
    assign err_index    = err_q;

endmodule

// File: tb/tb_sensor_init_seq.sv
// tb_sensor_init_seq: directed bench with a ROM model, an I2C master model and
// an expected-request queue. A second instance with MAX_RETRY=0 and no
// responder covers the ack timeout.
module tb_sensor_init_seq;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          init_start = 1'b0;
    logic          init_done, init_err, busy;
    logic [AW-1:0] rom_addr, err_index;
    logic [15:0]   rom_data = 16'h0000;
    logic          i2c_req;
    logic [7:0]    i2c_reg_addr, i2c_wr_data;
    logic          i2c_done = 1'b0;
    logic          i2c_nack = 1'b0;

    logic          t_start = 1'b0;
    logic          t_done, t_err, t_busy, t_req;
    logic [AW-1:0] t_rom_addr, t_err_index;
    logic [15:0]   t_rom_data = 16'h1234;
    logic [7:0]    t_reg_addr, t_wr_data;
    logic          t_i2c_done = 1'b0;
    logic          t_i2c_nack = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [15:0] rom_mem [0:(1<<AW)-1];
    logic [15:0] exp_q [$];
    bit          nack_q [$];
    int          req_cyc_q [$];
    int          req_cnt = 0;
    int          ack_lat = 1;

    sensor_init_seq #(
        .NUM_ENTRIES(2), .ROM_AW(AW), .DELAY_UNIT(10), .MAX_RETRY(3), .ACK_TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(reset), .init_start(init_start),
        .init_done(init_done), .init_err(init_err), .busy(busy),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .i2c_req(i2c_req), .i2c_reg_addr(i2c_reg_addr), .i2c_wr_data(i2c_wr_data),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack), .err_index(err_index)
    );

    sensor_init_seq #(
        .NUM_ENTRIES(1), .ROM_AW(AW), .DELAY_UNIT(10), .MAX_RETRY(0), .ACK_TIMEOUT(20)
    ) u_to (
        .clk(clk), .reset(reset), .init_start(t_start),
        .init_done(t_done), .init_err(t_err), .busy(t_busy),
        .rom_addr(t_rom_addr), .rom_data(t_rom_data),
        .i2c_req(t_req), .i2c_reg_addr(t_reg_addr), .i2c_wr_data(t_wr_data),
        .i2c_done(t_i2c_done), .i2c_nack(t_i2c_nack), .err_index(t_err_index)
    );

    // Clock, cycle counter and one-cycle-latency ROM.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(output int s);
        @(posedge clk); #1;
        init_start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        init_start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done || init_err) begin
                at = cyc;
                break;
            end
        end
        check("end_reached", (at >= 0), 1);
    endtask

    task automatic new_run(input logic [15:0] w0, input logic [15:0] w1, input int lat);
        rom_mem[0] = w0;
        rom_mem[1] = w1;
        ack_lat = lat;
        req_cnt = 0;
        req_cyc_q.delete();
        exp_q.delete();
        nack_q.delete();
    endtask

    // I2C master model: checks each request against the scoreboard, then
    // answers after ack_lat cycles with the next planned NACK bit.
    initial begin
        forever begin
            @(negedge clk);
            if (i2c_req) begin
                logic [15:0] exp_w;
                bit          nk;
                req_cnt++;
                req_cyc_q.push_back(cyc);
                check("req_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check("req_word", {i2c_reg_addr, i2c_wr_data}, exp_w);
                end
                nk = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                repeat (ack_lat) @(posedge clk);
                #1;
                i2c_done = 1'b1;
                i2c_nack = nk;
                @(posedge clk); #1;
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
        end
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    // Directed sequence.
    initial begin
        int s, s2, e, t_req_at, t_err_at, t_reqs;
        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 16'h0000;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {init_done, init_err, busy, rom_addr, i2c_req, i2c_reg_addr, i2c_wr_data, err_index}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic run, ack after 10 cycles.
        new_run(16'h1280, 16'h0C04, 10);
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h0C04);
        pulse_start(s);
        wait_end(200, e);
        check("basic_done", init_done, 1);
        check("basic_err", init_err, 0);
        check("basic_busy", busy, 0);
        check("basic_reqs", req_cnt, 2);
        check("basic_latency", e - s, 31);
        repeat (5) @(negedge clk);
        check("basic_done_holds", init_done, 1);

        // Minimum latency restart from DONE with immediate ack.
        new_run(16'h1280, 16'h0C04, 1);
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h0C04);
        pulse_start(s);
        wait_end(200, e);
        check("fast_first_req", (req_cyc_q.size() > 0) ? req_cyc_q[0] - s : -1, 4);
        check("fast_latency", e - s, 13);
        check("fast_done", init_done, 1);

        // Delay entry: 3 ticks of 10 cycles.
        new_run(16'hFF03, 16'h3A05, 1);
        exp_q.push_back(16'h3A05);
        pulse_start(s);
        repeat (18) @(negedge clk);
        check("delay_busy", busy, 1);
        wait_end(200, e);
        check("delay_req_at", (req_cyc_q.size() > 0) ? req_cyc_q[0] - s : -1, 38);
        check("delay_reqs", req_cnt, 1);
        check("delay_done", init_done, 1);
        check("delay_latency", e - s, 41);

        // Zero-tick delay entry skips DELAY.
        new_run(16'hFF00, 16'h3A05, 1);
        exp_q.push_back(16'h3A05);
        pulse_start(s);
        wait_end(200, e);
        check("zero_delay_req_at", (req_cyc_q.size() > 0) ? req_cyc_q[0] - s : -1, 8);
        check("zero_delay_done", init_done, 1);

        // NACK twice on entry 0, then ack.
        new_run(16'h1280, 16'h0C04, 3);
        for (int i = 0; i < 3; i++) exp_q.push_back(16'h1280);
        exp_q.push_back(16'h0C04);
        nack_q = '{1'b1, 1'b1, 1'b0, 1'b0};
        pulse_start(s);
        wait_end(400, e);
        check("retry_reqs", req_cnt, 4);
        check("retry_done", init_done, 1);
        check("retry_err", init_err, 0);

        // Entry 1 always NACKed: retry exhaustion.
        new_run(16'h1280, 16'h0C04, 2);
        exp_q.push_back(16'h1280);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h0C04);
        nack_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        pulse_start(s);
        wait_end(400, e);
        check("exhaust_reqs", req_cnt, 5);
        check("exhaust_err", init_err, 1);
        check("exhaust_index", err_index, 1);
        check("exhaust_done", init_done, 0);
        check("exhaust_busy", busy, 0);
        check("exhaust_left", exp_q.size(), 0);

        // Restart from ERROR; a second start during WAIT_ACK is ignored.
        new_run(16'h1280, 16'h0C04, 10);
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h0C04);
        pulse_start(s);
        @(negedge clk);
        check("restart_cleared", {init_err, err_index, busy}, 1);
        repeat (4) @(posedge clk);
        pulse_start(s2);
        wait_end(200, e);
        check("ignore_reqs", req_cnt, 2);
        check("ignore_latency", e - s, 31);
        check("ignore_done", init_done, 1);

        // Reset while in DELAY, then a fresh start from index 0.
        new_run(16'hFF03, 16'h3A05, 1);
        pulse_start(s);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_in_delay",
              {init_done, init_err, busy, rom_addr, i2c_req, i2c_reg_addr, i2c_wr_data, err_index}, 0);
        check("reset_no_req", req_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        new_run(16'h1280, 16'h0C04, 1);
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h0C04);
        pulse_start(s);
        @(negedge clk);
        check("fresh_rom_addr", rom_addr, 0);
        wait_end(200, e);
        check("fresh_latency", e - s, 13);
        check("fresh_reqs", req_cnt, 2);

        // Ack timeout on the non-responding instance.
        @(posedge clk); #1;
        t_start = 1'b1;
        @(posedge clk); #1;
        t_start = 1'b0;
        t_req_at = -1;
        t_err_at = -1;
        t_reqs = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (t_req) begin
                t_reqs++;
                t_req_at = cyc;
            end
            if (t_err) begin
                t_err_at = cyc;
                break;
            end
        end
        check("to_err_seen", (t_err_at >= 0), 1);
        check("to_latency", t_err_at - t_req_at, 20);
        check("to_reqs", t_reqs, 1);
        check("to_state", {t_done, t_busy, t_err_index}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sensor_init_seq.md
Name: sensor_init_seq

Overview:
- Initialization sequencer for the image-capture path.
- Consumes the top-level controller's one-cycle init_start pulse and walks a register-write table held in an external synchronous ROM.
- Issues each write to the shared I2C master, inserts programmable delays, and reports completion on init_done or failure on init_err.
- Sits between the top-level control FSM and the I2C master that serves both camera sensors.

Parameters:
NUM_ENTRIES, 64, number of valid ROM entries (1..2^ROM_AW)
ROM_AW, 6, ROM address width
DELAY_UNIT, 50000, clk cycles per delay tick
MAX_RETRY, 3, NACK retries per entry before error
ACK_TIMEOUT, 100000, clk cycles to wait for i2c_done before treating the entry as a NACK

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
init_start  in  1  one-cycle start pulse from the top-level controller
init_done  out  1  level; high after all entries succeed
init_err  out  1  level; high after retry exhaustion
busy  out  1  high from accepted start until DONE or ERROR
rom_addr  out  ROM_AW  ROM read address
rom_data  in  16  ROM entry, valid one cycle after rom_addr; {reg_addr[15:8], reg_data[7:0]}
i2c_req  out  1  one-cycle write request
i2c_reg_addr  out  8  register sub-address, held stable from i2c_req until i2c_done
i2c_wr_data  out  8  write data, held like i2c_reg_addr
i2c_done  in  1  one-cycle completion pulse from the I2C master
i2c_nack  in  1  qualified by i2c_done; 1 = transfer not acknowledged
err_index  out  ROM_AW  index of the failing entry; valid while init_err is high

Behaviour:
- Reset (synchronous, active-high, wins over every other input): state IDLE; all outputs 0; index, retry and delay counters 0.
- States:
  - IDLE: on init_start go to FETCH with index 0; clear init_done, init_err and err_index.
  - FETCH: drive rom_addr=index; go to LATCH.
  - LATCH: capture rom_data (one-cycle ROM latency); go to DECODE.
  - DECODE:
    - reg_addr==8'hFF is a delay entry: load delay_cnt = reg_data*DELAY_UNIT; go to DELAY. reg_data==0 gives zero delay, so go directly to NEXT.
    - Any other value: go to ISSUE with retry=0.
  - ISSUE: pulse i2c_req for exactly 1 cycle with address/data; clear timeout counter; go to WAIT_ACK.
  - WAIT_ACK:
    - i2c_done && !i2c_nack: go to NEXT.
    - i2c_done && i2c_nack, or timeout reaching ACK_TIMEOUT: if retry<MAX_RETRY then retry+1 and back to ISSUE; else go to ERROR.
  - DELAY: decrement delay_cnt each cycle; at 1 go to NEXT. A delay of N ticks spends exactly N*DELAY_UNIT cycles in DELAY.
  - NEXT: if index==NUM_ENTRIES-1 go to DONE; else index+1 and go to FETCH.
  - DONE: init_done=1, busy=0. init_start clears init_done and restarts at index 0.
  - ERROR: init_err=1, err_index=index, busy=0. init_start restarts as from IDLE.
- busy=1 in every state except IDLE, DONE and ERROR.
- init_start is ignored while busy (no restart, no queueing).
- i2c_done in any state other than WAIT_ACK is ignored.
- Minimum latency from init_start to init_done for one write entry with immediate ack: init_start at cycle 0; FETCH 1, LATCH 2, DECODE 3, ISSUE 4 (i2c_req), i2c_done sampled at 5, NEXT 6, init_done high at 7.
- Retry count applies per entry and resets to 0 for each new entry.
- Timeout counter width is ceil(log2(ACK_TIMEOUT+1)). delay_cnt width covers 255*DELAY_UNIT.
- Reset mid-sequence aborts immediately: i2c_req drops the same cycle. The I2C master is expected to be reset by the same reset.
- init_done and init_err are never high simultaneously.

Test Plan:
- Basic run: NUM_ENTRIES=2, ROM = {0x1280, 0x0C04}, master acks after 10 cycles -> two i2c_req pulses with (0x12,0x80) then (0x0C,0x04); init_done rises and stays high; init_err=0.
- Delay entry: DELAY_UNIT=10, ROM = {0xFF03, 0x3A05} -> exactly 30 cycles in DELAY, then a single request (0x3A,0x05); init_done=1.
- NACK retry: MAX_RETRY=3; entry 0 NACKed twice then acked -> 3 i2c_req pulses, same address/data each time; init_done=1.
- Retry exhaustion: entry 1 always NACKed -> 4 requests for entry 1, then init_err=1, err_index=1, init_done=0, busy=0.
- Timeout: i2c_done never asserted, ACK_TIMEOUT=20, MAX_RETRY=0 -> init_err=1 exactly 20 cycles after i2c_req.
- Disturbances: init_start pulsed during WAIT_ACK -> ignored. Reset asserted in DELAY -> next cycle state IDLE with all outputs 0. A fresh init_start afterwards starts again from index 0.
